// File: rtl/vga_params_pkg.sv
// ============================================================================
// Module      : vga_params (package)
// Description : 640x480@60 Hz raster timing constants shared by the timing
//               generator and the downstream colour stage, plus a small
//               inclusive range-test helper used by the visible-area decodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_params;

  localparam int COUNT_W         = 10;

  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END   = 783;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END   = 514;

  // Inclusive unsigned window test on counter-width values.
  function automatic logic in_range(input logic [COUNT_W-1:0] v,
                                    input logic [COUNT_W-1:0] lo,
                                    input logic [COUNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_clk_div_strobe.sv
// ============================================================================
// Module      : clk_div_strobe
// Description : Modulo-CLK_DIV counter producing a registered one-clock
//               strobe on every wrap.
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   o_tick   out combinational "wrap happens on this edge" (counter enable)
//   o_pix_en out registered strobe, high for the clock after each wrap
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_strobe #(
  parameter int CLK_DIV = 4      // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick,
  output logic o_pix_en
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] c_last = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_en;
  logic             w_wrap;

  assign w_wrap = (r_div_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else begin
      r_pix_en  <= w_wrap;
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
    end
  end

  // The counters downstream update on the same edge that raises o_pix_en,
  // so they need the pre-register wrap condition as their enable.
  assign o_tick   = w_wrap;
  assign o_pix_en = r_pix_en;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Divides clk down to a pixel
//               strobe, runs horizontal/vertical counters and registers the
//               sync, visible-area and line/frame markers in the same stage
//               as the counters, so every output describes the hCount/vCount
//               presented alongside it.
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   pix_en      out one-clock pixel strobe every CLK_DIV clocks
//   hCount      out horizontal position 0..H_TOTAL-1
//   vCount      out vertical position 0..V_TOTAL-1
//   hSync       out active-low horizontal sync
//   vSync       out active-low vertical sync
//   bright      out visible-window flag
//   line_start  out one-clock pulse when hCount becomes 0
//   frame_start out one-clock pulse when hCount and vCount both become 0
//   frame_count out completed frames, mod 256
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_params::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam logic [COUNT_W-1:0] c_h_last  = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] c_v_last  = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] c_h_sync  = COUNT_W'(H_SYNC);
  localparam logic [COUNT_W-1:0] c_v_sync  = COUNT_W'(V_SYNC);
  localparam logic [COUNT_W-1:0] c_h_vis_s = COUNT_W'(H_VIS_START);
  localparam logic [COUNT_W-1:0] c_h_vis_e = COUNT_W'(H_VIS_END);
  localparam logic [COUNT_W-1:0] c_v_vis_s = COUNT_W'(V_VIS_START);
  localparam logic [COUNT_W-1:0] c_v_vis_e = COUNT_W'(V_VIS_END);

  logic               w_tick;
  logic               w_h_last;
  logic               w_v_last;
  logic [COUNT_W-1:0] w_h_nxt;
  logic [COUNT_W-1:0] w_v_nxt;

  logic [COUNT_W-1:0] r_h_count;
  logic [COUNT_W-1:0] r_v_count;
  logic               r_h_sync;
  logic               r_v_sync;
  logic               r_bright;
  logic               r_line_start;
  logic               r_frame_start;
  logic [7:0]         r_frame_count;

  clk_div_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .o_tick   (w_tick),
    .o_pix_en (pix_en)
  );

  assign w_h_last = (r_h_count == c_h_last);
  assign w_v_last = (r_v_count == c_v_last);

  // Next counter values; the decodes below are taken from these so the
  // registered sync/bright line up with the registered counters.
  always_comb begin
    w_h_nxt = r_h_count;
    w_v_nxt = r_v_count;
    if (w_tick) begin
      if (w_h_last) begin
        w_h_nxt = '0;
        w_v_nxt = w_v_last ? '0 : r_v_count + 1'b1;
      end else begin
        w_h_nxt = r_h_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_h_sync      <= 1'b0;
      r_v_sync      <= 1'b0;
      r_bright      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      // Markers are single-clock: cleared on every edge that is not a wrap.
      r_line_start  <= w_tick && w_h_last;
      r_frame_start <= w_tick && w_h_last && w_v_last;
      if (w_tick) begin
        r_h_count <= w_h_nxt;
        r_v_count <= w_v_nxt;
        r_h_sync  <= (w_h_nxt >= c_h_sync);
        r_v_sync  <= (w_v_nxt >= c_v_sync);
        r_bright  <= in_range(w_h_nxt, c_h_vis_s, c_h_vis_e) &&
                     in_range(w_v_nxt, c_v_vis_s, c_v_vis_e);
        if (w_h_last && w_v_last) begin
          r_frame_count <= r_frame_count + 8'd1;
        end
      end
    end
  end

  assign hCount      = r_h_count;
  assign vCount      = r_v_count;
  assign hSync       = r_h_sync;
  assign vSync       = r_v_sync;
  assign bright      = r_bright;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench. u_a uses the full 640x480 timing for
//               reset release and line-level checks; u_b uses a tiny raster
//               (8x6 pixels, CLK_DIV=2, 96 clocks per frame) so that frame
//               wrap, 256-frame counter wrap and mid-frame reset fit in a
//               short run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  // small-raster geometry for u_b
  localparam int B_CD  = 2;
  localparam int B_HT  = 8;
  localparam int B_HS  = 2;
  localparam int B_HVS = 3;
  localparam int B_HVE = 6;
  localparam int B_VT  = 6;
  localparam int B_VS  = 1;
  localparam int B_VVS = 2;
  localparam int B_VVE = 4;
  localparam int B_FRAME = B_HT * B_VT * B_CD;   // 96 clocks

  logic clk = 1'b0;
  logic rst_a, rst_b;

  logic       a_pix_en, a_hsync, a_vsync, a_bright, a_ls, a_fs;
  logic [9:0] a_h, a_v;
  logic [7:0] a_fc;
  logic       b_pix_en, b_hsync, b_vsync, b_bright, b_ls, b_fs;
  logic [9:0] b_h, b_v;
  logic [7:0] b_fc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .pix_en(a_pix_en), .hCount(a_h), .vCount(a_v),
    .hSync(a_hsync), .vSync(a_vsync), .bright(a_bright), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(B_CD), .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_VIS_START(B_HVS),
    .H_VIS_END(B_HVE), .V_TOTAL(B_VT), .V_SYNC(B_VS), .V_VIS_START(B_VVS),
    .V_VIS_END(B_VVE)
  ) u_b (
    .clk(clk), .rst(rst_b), .pix_en(b_pix_en), .hCount(b_h), .vCount(b_v),
    .hSync(b_hsync), .vSync(b_vsync), .bright(b_bright), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected u_b outputs after edge e counted from the rst-low edge (e=0 is
  // the reset state). Pixel tick k lands on edge k*CLK_DIV.
  task automatic check_b(input int e);
    int t, h, v, fc, pe;
    t  = e / B_CD;
    h  = t % B_HT;
    v  = (t / B_HT) % B_VT;
    fc = (t / (B_HT * B_VT)) % 256;
    pe = (e > 0 && (e % B_CD) == 0) ? 1 : 0;
    chk("b_pix_en", b_pix_en, pe);
    chk("b_hCount", b_h, h);
    chk("b_vCount", b_v, v);
    chk("b_hSync", b_hsync, (h >= B_HS) ? 1 : 0);
    chk("b_vSync", b_vsync, (v >= B_VS) ? 1 : 0);
    chk("b_bright", b_bright,
        (h >= B_HVS && h <= B_HVE && v >= B_VVS && v <= B_VVE) ? 1 : 0);
    chk("b_line_start", b_ls, (pe == 1 && h == 0) ? 1 : 0);
    chk("b_frame_start", b_fs, (pe == 1 && h == 0 && v == 0) ? 1 : 0);
    chk("b_frame_count", b_fc, fc);
  endtask

  task automatic check_b_reset();
    chk("b_rst_pix_en", b_pix_en, 0);
    chk("b_rst_hCount", b_h, 0);
    chk("b_rst_vCount", b_v, 0);
    chk("b_rst_hSync", b_hsync, 0);
    chk("b_rst_vSync", b_vsync, 0);
    chk("b_rst_bright", b_bright, 0);
    chk("b_rst_line_start", b_ls, 0);
    chk("b_rst_frame_start", b_fs, 0);
    chk("b_rst_frame_count", b_fc, 0);
  endtask

  initial begin
    int pix_cnt, ls_early, hs_low, ls_win, br_win, pix_win;
    int fs_cnt, vs_low, br_frm;
    int e_mid;

    rst_a = 1'b1;
    rst_b = 1'b1;

    // ---------------- u_a: reset release ----------------
    repeat (3) step();
    chk("a_rst_pix_en", a_pix_en, 0);
    chk("a_rst_hCount", a_h, 0);
    chk("a_rst_vCount", a_v, 0);
    chk("a_rst_hSync", a_hsync, 0);
    chk("a_rst_vSync", a_vsync, 0);
    chk("a_rst_bright", a_bright, 0);
    chk("a_rst_line_start", a_ls, 0);
    chk("a_rst_frame_start", a_fs, 0);
    chk("a_rst_frame_count", a_fc, 0);

    @(negedge clk);
    rst_a = 1'b0;
    pix_cnt = 0; ls_early = 0; hs_low = 0; ls_win = 0; br_win = 0; pix_win = 0;
    for (int e = 1; e <= 6399; e++) begin
      step();
      if (e < 3200) begin
        pix_cnt += a_pix_en;
        ls_early += a_ls;
      end
      if (e == 3) begin
        chk("a_pix_en_e3", a_pix_en, 0);
        chk("a_hCount_e3", a_h, 0);
      end
      if (e == 4) begin
        chk("a_first_pix_en", a_pix_en, 1);
        chk("a_first_hCount", a_h, 1);
        chk("a_first_ls", a_ls, 0);
      end
      if (e == 5) begin
        chk("a_pix_en_e5", a_pix_en, 0);
        chk("a_hCount_e5", a_h, 1);
      end
      if (e == 3196) begin
        chk("a_hCount_799", a_h, 799);
        chk("a_vCount_799", a_v, 0);
        chk("a_hSync_799", a_hsync, 1);
      end
      if (e == 3200) begin
        pix_cnt += a_pix_en;
        chk("a_strobes_line0", pix_cnt, 800);
        chk("a_ls_powerup", ls_early, 0);
        chk("a_hwrap_hCount", a_h, 0);
        chk("a_hwrap_vCount", a_v, 1);
        chk("a_hwrap_line_start", a_ls, 1);
        chk("a_hwrap_frame_start", a_fs, 0);
      end
      if (e == 3201) chk("a_ls_single", a_ls, 0);
      // window covering exactly line 1: states after edges 3200..6399
      if (e >= 3200) begin
        hs_low  += (a_hsync == 1'b0) ? 1 : 0;
        ls_win  += a_ls;
        br_win  += a_bright;
        pix_win += a_pix_en;
      end
    end
    chk("a_hsync_low_clks", hs_low, 384);
    chk("a_line_start_cnt", ls_win, 1);
    chk("a_bright_line1", br_win, 0);
    chk("a_strobes_line1", pix_win, 800);
    chk("a_vsync_line1", a_vsync, 0);

    // ---------------- u_b: frames, wrap, mid-frame reset ----------------
    rst_a = 1'b1;
    check_b_reset();
    @(negedge clk);
    rst_b = 1'b0;
    check_b(0);
    fs_cnt = 0; vs_low = 0; br_frm = 0;
    e_mid = 256 * B_FRAME + 58;
    for (int e = 1; e <= e_mid; e++) begin
      step();
      check_b(e);
      if (e <= 2 * B_FRAME) fs_cnt += b_fs;
      if (e >= B_FRAME && e < 2 * B_FRAME) begin
        vs_low += (b_vsync == 1'b0) ? 1 : 0;
        br_frm += b_bright;
      end
      if (e == B_FRAME - 1)   chk("b_fs_before_96", b_fs, 0);
      if (e == B_FRAME) begin
        chk("b_fs_96", b_fs, 1);
        chk("b_fc_frame1", b_fc, 1);
      end
      if (e == 2 * B_FRAME)   chk("b_fc_frame2", b_fc, 2);
      if (e == 255 * B_FRAME) chk("b_fc_255", b_fc, 255);
      if (e == 256 * B_FRAME) begin
        chk("b_fc_wrap", b_fc, 0);
        chk("b_fs_at_wrap", b_fs, 1);
        chk("b_h_at_wrap", b_h, 0);
        chk("b_v_at_wrap", b_v, 0);
      end
    end
    chk("b_fs_count_2frames", fs_cnt, 2);
    chk("b_vsync_low_clks", vs_low, 16);
    chk("b_bright_clks", br_frm, 24);
    chk("b_mid_hCount", b_h, 5);
    chk("b_mid_vCount", b_v, 3);

    @(negedge clk);
    rst_b = 1'b1;
    step();
    check_b_reset();
    @(negedge clk);
    rst_b = 1'b0;
    for (int e = 1; e <= B_FRAME; e++) begin
      step();
      check_b(e);
      if (e == B_FRAME - 1) chk("b_rst_fs_before", b_fs, 0);
      if (e == B_FRAME) begin
        chk("b_rst_fs_after", b_fs, 1);
        chk("b_rst_fc_after", b_fc, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA path. It divides the 100 MHz system clock to a 25 MHz pixel strobe and runs the horizontal and vertical counters. It produces registered hSync/vSync, the `bright` visible-area flag, and frame/line markers. It sits directly upstream of the pixel colour stage, which consumes `hCount`, `vCount` and `bright`.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; must be ≥ 2.
- `H_TOTAL`, 800: pixels per line.
- `H_SYNC`, 96: hSync low width, starting at hCount 0.
- `H_VIS_START`, 144: first visible hCount.
- `H_VIS_END`, 783: last visible hCount.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync low width, starting at vCount 0.
- `V_VIS_START`, 35: first visible vCount.
- `V_VIS_END`, 514: last visible vCount.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `pix_en` out 1: one-`clk` pixel strobe, high once every CLK_DIV cycles.
- `hCount` out 10: horizontal position, 0..H_TOTAL-1.
- `vCount` out 10: vertical position, 0..V_TOTAL-1.
- `hSync` out 1: active-low horizontal sync.
- `vSync` out 1: active-low vertical sync.
- `bright` out 1: high inside the visible window.
- `line_start` out 1: one-`clk` pulse when hCount becomes 0.
- `frame_start` out 1: one-`clk` pulse when hCount and vCount both become 0.
- `frame_count` out 8: frames completed, mod 256.

## Operation
- `div_cnt` runs 0..CLK_DIV-1 and wraps to 0. `pix_en` is registered and goes high on the edge where `div_cnt` wraps.
- Counters change only on edges where `pix_en` is high:
  - `hCount` increments. At H_TOTAL-1 it wraps to 0 and `vCount` advances.
  - `vCount` wraps from V_TOTAL-1 to 0. `frame_count` increments on that same edge and wraps at 255 to 0.
- Sync and visible-area decodes are computed from the next counter values and registered on the same edge as the counters. Every output is therefore a flop aligned with the `hCount`/`vCount` it describes:
  - `hSync` = 0 iff hCount < H_SYNC.
  - `vSync` = 0 iff vCount < V_SYNC.
  - `bright` = H_VIS_START ≤ hCount ≤ H_VIS_END and V_VIS_START ≤ vCount ≤ V_VIS_END.
- `line_start` is high for exactly one `clk` after the edge where hCount wraps to 0.
- `frame_start` is high for exactly one `clk` after the edge where both counters wrap to 0.
- There is no state machine beyond the divider and the two counters. Out-of-range counter values cannot occur; comparisons are unsigned on 10 bits.

## Timing
- Reset values (rst high at an edge): `div_cnt`=0, `pix_en`=0, `hCount`=0, `vCount`=0, `hSync`=0, `vSync`=0, `bright`=0, `line_start`=0, `frame_start`=0, `frame_count`=0.
- The first `pix_en` occurs CLK_DIV edges after the rst-low edge. `hCount`=1 is visible on that same edge.
- Reset at power-up does not pulse `line_start` or `frame_start`. The first `frame_start` follows one full frame: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clocks.
- Latency from counter value to sync/bright is 0 cycles (same register stage).
- Outputs are stable for CLK_DIV clocks between `pix_en` edges. The downstream colour stage samples them combinationally.
- Reset mid-frame returns all state to the reset values on the next edge. Counting restarts exactly as from power-up.
- Simultaneous h-wrap, v-wrap and frame_count wrap on one edge is legal. All three update together.

## Structure
- Shared package/include `vga_params`: 640x480 timing constants (the totals, sync widths, visible bounds) and `COUNT_W = 10`. The colour stage uses the same visible-bound constants.
- One natural sub-module: `clk_div_strobe`, a parameterised modulo-CLK_DIV counter emitting `pix_en`. The h/v counters and decodes stay in the top.

## Test plan
- Reset release: `rst` held 3 cycles → all outputs at reset values. First `pix_en` exactly 4 clocks after release, with `hCount`=1.
- Line timing: after reset, count `pix_en` → `hCount` 799→0 and `vCount` 0→1 on the 800th strobe. `line_start` is a single-clock pulse. `hSync` is low for exactly 96*4 = 384 clocks per line.
- Visible window: scan one frame → `bright` high only for hCount 144..783 with vCount 35..514. `bright` is high for 640*480*4 = 1,228,800 clocks per frame.
- Frame wrap: run 2 frames → `frame_start` pulses at clocks 1,680,000 and 3,360,000. `vSync` is low for 2 lines (6,400 clocks). `frame_count` reads 1 then 2.
- frame_count wrap: run 256 frames, or force the count to 255 → goes to 0 on the next frame wrap. `frame_start` still pulses.
- Mid-frame reset: assert `rst` at hCount=400, vCount=200 for one clock → next edge shows all reset values. The next `frame_start` comes 1,680,000 clocks after release.
